rr_mux_sel_arbiter: RTL and testbench
=====================================

Name: rr_mux_sel_arbiter

Overview:
Round-robin arbiter that generates the 2-bit select for the 4:1 mux stage directly downstream. Four requesters compete for the shared mux output. The block grants one requester at a time, holds the grant for at most MAX_HOLD cycles, and drives sel/gnt from registers so the mux select is glitch-free. Embedded immediate assertions check grant/select consistency every cycle.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 2..255.
CNT_W, $clog2(MAX_HOLD+1), width of the hold counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; 0 forces release
req  input  4  request vector, bit i = requester i (bit 0 = a, 1 = b, 2 = c, 3 = d)
gnt  output  4  registered one-hot grant; 0 when idle
sel  output  2  registered binary index of current/last owner; drives mux sel
gnt_valid  output  1  registered; 1 iff gnt != 0
hold_cnt  output  CNT_W  registered count of cycles the current owner has held the grant

Behaviour:
- Reset (async on rst_n=0; release is synchronous to clk):
  - gnt=4'b0000, sel=2'b00, gnt_valid=0, hold_cnt=0.
  - state=IDLE, priority pointer ptr=0.
  - An assertion of rst_n mid-grant takes effect immediately, with no completion of the hold.
- State machine has two states, IDLE and GRANT. All outputs are registered; latency from a req edge to gnt is 1 clock.
- IDLE:
  - gnt=0, gnt_valid=0, hold_cnt=0.
  - sel holds its last value, so the mux output stays stable.
  - If en=1 and req!=0: select the first set bit searching ptr, ptr+1, ... modulo 4.
  - Next cycle: gnt=onehot(w), sel=w, gnt_valid=1, hold_cnt=0, state goes to GRANT.
- GRANT, with owner o=sel. Evaluated each cycle, in priority order:
  1. en=0: go to IDLE next cycle (gnt=0); ptr=o+1.
  2. req[o]=0 (owner dropped):
     - If another req is set, grant the next requester after o in rotating order directly, with no idle bubble; hold_cnt=0; ptr=o+1.
     - Otherwise go to IDLE; ptr=o+1.
  3. hold_cnt==MAX_HOLD-1 and any req[j], j!=o, is set (expiry): grant the next requester after o directly; hold_cnt=0; ptr=o+1.
  4. hold_cnt==MAX_HOLD-1 and no other request: keep o; hold_cnt wraps to 0 (re-grant, no bubble).
  5. Otherwise: keep o; hold_cnt+1.
- Rotation order is modulo 4. After owner 3 the search starts at 0.
- Simultaneous events:
  - New requests arriving in the same cycle as a release are included in the search.
  - An owner re-asserting req in the cycle it is released is treated as lowest priority, since the search starts at o+1.
- hold_cnt never exceeds MAX_HOLD-1.
- Embedded assertions (immediate, in a clocked procedural block, skipped while rst_n=0). Each fails with $error including $time:
  - gnt is one-hot or zero.
  - gnt_valid == (gnt != 0).
  - gnt_valid implies gnt[sel]==1.
  - hold_cnt < MAX_HOLD.
  - gnt_valid implies that req[sel] was 1 in the previous cycle (a granted owner had a request).

Test Plan:
- Reset: drive req=4'b1111, en=1, rst_n=0 for 3 clocks -> gnt=0, sel=0, gnt_valid=0. Release rst_n -> gnt=4'b0001, sel=0 one clock later.
- Single requester: req=4'b0100 held 20 cycles, MAX_HOLD=8 -> gnt=4'b0100 continuously; hold_cnt counts 0..7 and wraps; no bubble, no assertion fires.
- Fairness: req=4'b1111 constant, MAX_HOLD=8 -> sel sequence 0,1,2,3,0, each held exactly 8 cycles; gnt changes the cycle after hold_cnt=7.
- Owner drop: owner 1 granted, req changes 4'b0010 -> 4'b1001 -> next cycle gnt=4'b1000 (search starts at 2, finds 3). Then req=0 -> IDLE with gnt=0, sel holds 3.
- Enable/reset mid-grant: owner 2 at hold_cnt=3; en=0 -> next cycle gnt=0. Re-enable with req=4'b0101 -> gnt=4'b0001 (ptr=3 wraps to 0). Then rst_n low asynchronously between edges -> outputs clear without waiting for a clock.
- Mux integration: connect sel to the downstream 4:1 mux with toggling a..d, req=4'b1111 for 100 cycles -> mux y equals the selected input every cycle; zero assertion failures in either block.

Source files
------------

// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - round-robin arbiter driving a registered 4:1 mux select
module rr_mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_HOLD);

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic             r_gnt_valid;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_req_prev;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [3:0]       w_owner_oh;
    logic [3:0]       w_others;
    logic [1:0]       w_after;
    logic             w_expired;

    // First set bit of v, searching start, start+1, ... modulo 4; caller guarantees v != 0.
    function automatic logic [1:0] f_rr_pick(input logic [3:0] v, input logic [1:0] start);
        logic [1:0] idx;
        f_rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (v[idx]) begin
                f_rr_pick = idx;
            end
        end
    endfunction

    // The owner is always the current select; others excludes it so it ranks last on rotation.
    assign w_owner_oh = 4'b0001 << r_sel;
    assign w_others   = req & ~w_owner_oh;
    assign w_after    = r_sel + 2'd1;
    assign w_expired  = (r_hold_cnt == LP_LAST);

    // Next-state and next-output decision for the two-state grant machine.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt  = 4'b0000;
                w_hold_nxt = '0;
                if (en && (req != 4'b0000)) begin
                    w_sel_nxt   = f_rr_pick(req, r_ptr);
                    w_gnt_nxt   = 4'b0001 << w_sel_nxt;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_hold_nxt  = '0;
                    w_ptr_nxt   = w_after;
                end else if (!req[r_sel]) begin
                    w_ptr_nxt  = w_after;
                    w_hold_nxt = '0;
                    if (w_others != 4'b0000) begin
                        w_sel_nxt = f_rr_pick(w_others, w_after);
                        w_gnt_nxt = 4'b0001 << w_sel_nxt;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                    end
                end else if (w_expired) begin
                    // Expiry hands over only when someone else waits; otherwise re-grant in place.
                    w_hold_nxt = '0;
                    if (w_others != 4'b0000) begin
                        w_sel_nxt = f_rr_pick(w_others, w_after);
                        w_gnt_nxt = 4'b0001 << w_sel_nxt;
                        w_ptr_nxt = w_after;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Register every output so the downstream mux select never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_gnt       <= 4'b0000;
            r_sel       <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt_valid <= (w_state_nxt == ST_GRANT);
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    // Consistency checks on the registered outputs; req is remembered for the ownership check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_prev <= 4'b0000;
        end else begin
            assert ($onehot0(r_gnt))
                else $error("rr_mux_sel_arbiter: gnt not one-hot/zero at %0t", $time);
            assert (r_gnt_valid == (r_gnt != 4'b0000))
                else $error("rr_mux_sel_arbiter: gnt_valid inconsistent at %0t", $time);
            assert (!r_gnt_valid || r_gnt[r_sel])
                else $error("rr_mux_sel_arbiter: gnt[sel] clear while valid at %0t", $time);
            assert (r_hold_cnt < LP_MAX)
                else $error("rr_mux_sel_arbiter: hold_cnt out of range at %0t", $time);
            assert (!r_gnt_valid || r_req_prev[r_sel])
                else $error("rr_mux_sel_arbiter: owner had no request at %0t", $time);
            r_req_prev <= req;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign gnt_valid = r_gnt_valid;
    assign hold_cnt  = r_hold_cnt;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// tb/tb_rr_mux_sel_arbiter.sv - directed bench with behavioural round-robin model
module tb_rr_mux_sel_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             gnt_valid;
    logic [CNT_W-1:0] hold_cnt;

    logic [7:0] mux_in [4];
    logic [7:0] mux_y;

    int checks = 0;
    int errors = 0;

    // Model state: plain integers describing who owns the mux and for how long.
    int m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;

    rr_mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    // Downstream 4:1 mux fed by the arbiter select.
    assign mux_y = mux_in[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Behavioural model of the arbitration rules.
    always @(posedge clk or negedge rst_n) begin
        logic [3:0] others;
        int nxt;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else if (m_busy == 0) begin
            if (en && req != 4'b0000) begin
                m_owner = search(req, m_ptr);
                m_busy = 1;
                m_cnt = 0;
            end
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            nxt = (m_owner + 1) % 4;
            if (!en) begin
                m_busy = 0; m_cnt = 0; m_ptr = nxt;
            end else if (!req[m_owner]) begin
                m_cnt = 0; m_ptr = nxt;
                if (others != 4'b0000) m_owner = search(others, nxt);
                else m_busy = 0;
            end else if (m_cnt == MAX_HOLD - 1) begin
                m_cnt = 0;
                if (others != 4'b0000) begin
                    m_owner = search(others, nxt);
                    m_ptr = nxt;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #2;
        chk("gnt",       int'(gnt),       m_busy ? (1 << m_owner) : 0);
        chk("sel",       int'(sel),       m_owner);
        chk("gnt_valid", int'(gnt_valid), m_busy);
        chk("hold_cnt",  int'(hold_cnt),  m_busy ? m_cnt : 0);
        chk("mux_y",     int'(mux_y),     int'(mux_in[m_owner]));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mux_in[i] = 8'(8'h10 * (i + 1));
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;

        // Reset held with every request active.
        step(3);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_gv",  int'(gnt_valid), 0);
        rst_n = 1'b1;
        step(1);
        chk("rel_gnt", int'(gnt), 1);
        chk("rel_sel", int'(sel), 0);

        // Fairness: each owner holds exactly MAX_HOLD cycles.
        step(7);
        chk("fair_hold7", int'(hold_cnt), 7);
        chk("fair_gnt0",  int'(gnt), 1);
        step(1);
        chk("fair_gnt1",  int'(gnt), 2);
        chk("fair_hold0", int'(hold_cnt), 0);
        step(8);
        chk("fair_gnt2", int'(gnt), 4);
        step(8);
        chk("fair_gnt3", int'(gnt), 8);
        step(8);
        chk("fair_wrap", int'(gnt), 1);

        // Single requester: owner 0 drops, c taken directly, then wraps in place.
        req = 4'b0100;
        step(1);
        chk("single_gnt", int'(gnt), 4);
        step(7);
        chk("single_hold7", int'(hold_cnt), 7);
        step(1);
        chk("single_wrap_gnt",  int'(gnt), 4);
        chk("single_wrap_hold", int'(hold_cnt), 0);
        step(12);

        // Owner drop: owner 1 replaced by 3, then idle with sel held.
        req = 4'b0010;
        step(1);
        chk("drop_own1", int'(gnt), 2);
        req = 4'b1001;
        step(1);
        chk("drop_gnt3", int'(gnt), 8);
        chk("drop_sel3", int'(sel), 3);
        req = 4'b0000;
        step(1);
        chk("idle_gnt", int'(gnt), 0);
        chk("idle_sel", int'(sel), 3);
        chk("idle_gv",  int'(gnt_valid), 0);

        // Disabled while idle: no grant even with requests.
        en = 1'b0;
        req = 4'b1111;
        step(2);
        chk("dis_idle_gv", int'(gnt_valid), 0);

        // Enable mid-grant, then re-enable with wrap of the pointer.
        en = 1'b1;
        req = 4'b0100;
        step(1);
        chk("en_own2", int'(gnt), 4);
        step(3);
        chk("en_hold3", int'(hold_cnt), 3);
        en = 1'b0;
        step(1);
        chk("en_off_gnt", int'(gnt), 0);
        en = 1'b1;
        req = 4'b0101;
        step(1);
        chk("reen_gnt", int'(gnt), 1);
        chk("reen_sel", int'(sel), 0);
        step(2);

        // Asynchronous reset between edges.
        req = 4'b0100;
        step(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_sel", int'(sel), 0);
        chk("async_gv",  int'(gnt_valid), 0);
        chk("async_hold", int'(hold_cnt), 0);
        step(2);
        rst_n = 1'b1;

        // Mux integration: all request, toggling data.
        req = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            step(1);
            for (int i = 0; i < 4; i++) mux_in[i] = 8'($urandom_range(0, 255));
        end
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
